w0rm_core_decode: RTL

Instruction decode stage of the W0RM core, directly downstream of the instruction fetch stage. It accepts 16-bit instructions and their PC from fetch, decodes operand fields, register indices and the sign-extended immediate, and presents a decoded bundle to the execute stage through a valid/ready handshake. A two-entry skid buffer keeps `decode_ready` a registered signal, so fetch never sees a combinational path from execute backpressure.

---
 rtl/w0rm_core_decode.sv | 111 +++++++++++
 1 files changed

// File: rtl/w0rm_core_decode.sv
// w0rm_core_decode: W0RM instruction decode stage with a two-entry skid buffer
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   inst_data_in/valid/pc_in    instruction word, valid and PC from fetch
//   decode_ready                registered accept indication back to fetch
//   exec_ready, flush           backpressure and redirect from execute
//   dec_*                       decoded bundle presented to execute
module w0rm_core_decode #(
   parameter int DATA_WIDTH = 32,
   parameter int INST_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [INST_WIDTH-1:0] inst_data_in,
   input  logic                  inst_valid_in,
   input  logic [DATA_WIDTH-1:0] inst_pc_in,
   output logic                  decode_ready,
   input  logic                  exec_ready,
   input  logic                  flush,
   output logic                  dec_valid,
   output logic [3:0]            dec_opcode,
   output logic [3:0]            dec_rd,
   output logic [3:0]            dec_rs1,
   output logic [3:0]            dec_rs2,
   output logic [DATA_WIDTH-1:0] dec_imm,
   output logic [DATA_WIDTH-1:0] dec_pc,
   output logic                  dec_writes_rd,
   output logic                  dec_illegal
);
   localparam int BW = 18 + 2 * DATA_WIDTH;
   logic [15:0] inst;
   logic [3:0] rd, rs1, rs2;
   logic [DATA_WIDTH-1:0] imm, sext8, zext4;
   logic wr, ill;
   logic [BW-1:0] dec_word, o_data, s_data;
   logic o_valid, s_valid, rdy, accept, xfer, o_load, s_load, o_valid_n, s_valid_n;
   assign inst = inst_data_in[15:0];
   assign sext8 = {{(DATA_WIDTH-8){inst[7]}}, inst[7:0]};
   assign zext4 = {{(DATA_WIDTH-4){1'b0}}, inst[3:0]};
   always_comb begin
      rd = 4'd0;
      rs1 = 4'd0;
      rs2 = 4'd0;
      imm = '0;
      wr = 1'b0;
      ill = 1'b0;
      case (inst[15:12])
         4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
            rd = inst[11:8];
            rs1 = inst[7:4];
            rs2 = inst[3:0];
            wr = 1'b1;
         end
         4'h6, 4'h7, 4'hA: begin
            rd = inst[11:8];
            rs1 = inst[7:4];
            imm = zext4;
            wr = 1'b1;
         end
         4'h8: begin
            rd = inst[11:8];
            imm = sext8;
            wr = 1'b1;
         end
         4'h9: begin
            rd = inst[11:8];
            rs1 = inst[11:8];
            imm = sext8;
            wr = 1'b1;
         end
         4'hB: begin
            rs2 = inst[11:8];
            rs1 = inst[7:4];
            imm = zext4;
         end
         4'hC: imm = {{(DATA_WIDTH-13){inst[11]}}, inst[11:0], 1'b0};
         4'hD: begin
            rs1 = inst[11:8];
            imm = {sext8[DATA_WIDTH-2:0], 1'b0};
         end
         4'hE, 4'hF: ill = 1'b1;
         default: ;
      endcase
   end
   assign dec_word = {inst[15:12], rd, rs1, rs2, imm, inst_pc_in, wr, ill};
   assign accept = inst_valid_in && rdy;
   assign xfer = o_valid && exec_ready;
   // O refills whenever it is empty or draining; the skid entry has priority to keep order
   assign o_load = (!o_valid || xfer) && (s_valid || accept);
   assign s_load = accept && o_valid && !xfer;
   assign o_valid_n = !flush && ((o_valid && !xfer) || s_valid || accept);
   assign s_valid_n = !flush && ((s_valid && !xfer) || s_load);
   always_ff @(posedge clk) begin
      if (reset) begin
         o_valid <= 1'b0;
         s_valid <= 1'b0;
         rdy <= 1'b0;
         o_data <= '0;
         s_data <= '0;
      end else begin
         o_valid <= o_valid_n;
         s_valid <= s_valid_n;
         rdy <= !s_valid_n;
         if (o_load) o_data <= s_valid ? s_data : dec_word;
         if (s_load) s_data <= dec_word;
      end
   end
   assign decode_ready = rdy;
   assign dec_valid = o_valid;
   assign {dec_opcode, dec_rd, dec_rs1, dec_rs2, dec_imm, dec_pc, dec_writes_rd, dec_illegal} = o_data;
endmodule
